// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The alignment check is only used when DMEM_MISALIGN_CHECK_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Legal pairs: full word at offset 0, halfword at an even offset, byte at its own offset.
  function automatic logic align_ok(input logic [3:0] be, input logic [1:0] off);
    logic ok_s;
    ok_s = 1'b0;
    if (be == (BE_BYTE << off)) begin
      ok_s = 1'b1;
    end else if (!off[0] && (be == (BE_HALF << off))) begin
      ok_s = 1'b1;
    end else if ((off == 2'd0) && (be == BE_WORD)) begin
      ok_s = 1'b1;
    end else begin
      ok_s = 1'b0;
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word RAM with per-byte write enables and synchronous read.
// Contents are deliberately not reset.
module dmem_sram_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane write and read of the addressed word on an enabled edge
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: valid/ready request, WAIT_CYCLES wait states, held response.
// Optional misaligned-access error reporting under DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e          state_r, state_s;
  logic [CW-1:0]   cnt_r;
  logic            we_r, err_r, rd_r;
  logic [AW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic [3:0]      be_r;

  logic            hs_s, err_s, access_s, use_req_s;
  logic            ram_we_s, ram_err_s;
  logic [AW-1:0]   ram_idx_s;
  logic [31:0]     ram_wdata_s, ram_rdata_s;
  logic [3:0]      ram_be_s, ram_wen_s;
  logic            unused_addr_s;

  assign hs_s = req_valid && (state_r == IDLE);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign err_s = !align_ok(req_be, req_addr[1:0]);
`else
  assign err_s = 1'b0;
`endif

  assign unused_addr_s = ^{req_addr[31:2+AW], req_addr[1:0]};

  // Next-state decode; also flags the edge on which the memory access happens
  always_comb begin
    state_s  = state_r;
    access_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          if (WAIT_CYCLES == 0) begin
            state_s  = RESP;
            access_s = 1'b1;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CW'(1)) begin
          state_s  = RESP;
          access_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // With zero wait states the access uses the live request, otherwise the latched one
  assign use_req_s   = (state_r == IDLE);
  assign ram_idx_s   = use_req_s ? req_addr[2 +: AW] : idx_r;
  assign ram_wdata_s = use_req_s ? req_wdata : wdata_r;
  assign ram_be_s    = use_req_s ? req_be    : be_r;
  assign ram_we_s    = use_req_s ? req_we    : we_r;
  assign ram_err_s   = use_req_s ? err_s     : err_r;
  assign ram_wen_s   = (access_s && ram_we_s && !ram_err_s) ? ram_be_s : 4'b0000;

  // State, wait counter and request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      rd_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 32'h0000_0000;
      be_r    <= 4'b0000;
    end else begin
      state_r <= state_s;
      if (hs_s) begin
        cnt_r   <= CW'(WAIT_CYCLES);
        we_r    <= req_we;
        err_r   <= err_s;
        rd_r    <= !req_we && !err_s;
        idx_r   <= req_addr[2 +: AW];
        wdata_r <= req_wdata;
        be_r    <= req_be;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  dmem_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .en    (access_s),
    .wen   (ram_wen_s),
    .addr  (ram_idx_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // RAM read data is registered and only enables its path while a load response is held
  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_err   = (state_r == RESP) && err_r;
  assign rsp_rdata = ((state_r == RESP) && rd_r) ? ram_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a 2-wait-state and a 0-wait-state responder driven by the same requests.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] qa[$];
  logic [32:0] qz[$];
  logic [31:0] ma [int];
  logic [31:0] mz [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(z_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic legal_pair(input logic [3:0] be, input logic [1:0] off);
    case ({be, off})
      {4'b1111, 2'd0}, {4'b0011, 2'd0}, {4'b1100, 2'd2},
      {4'b0001, 2'd0}, {4'b0010, 2'd1}, {4'b0100, 2'd2}, {4'b1000, 2'd3}: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_err(input logic [3:0] be, input logic [1:0] off);
`ifdef DMEM_MISALIGN_CHECK_EN
    return !legal_pair(be, off);
`else
    return 1'b0;
`endif
  endfunction

  // Reference memory per DUT; returns the expected response data
  function automatic logic [31:0] mdl_access(input int which, input logic we, input logic [31:0] addr,
                                             input logic [31:0] wdata, input logic [3:0] be, input logic err);
    int idx;
    logic [31:0] cur;
    idx = int'(addr[11:2]);
    cur = 32'h0;
    if (which == 0) begin
      if (ma.exists(idx)) cur = ma[idx];
    end else begin
      if (mz.exists(idx)) cur = mz[idx];
    end
    if (err) return 32'h0;
    if (!we) return cur;
    for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
    if (which == 0) ma[idx] = cur; else mz[idx] = cur;
    return 32'h0;
  endfunction

  // Response consumption: pop and compare when a response is taken
  always @(negedge clk) begin
    logic [32:0] e;
    if (a_rsp_valid && rsp_ready) begin
      if (qa.size() == 0) check("a_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = qa.pop_front();
        check("a_rdata", a_rsp_rdata, e[31:0]);
        check("a_err", a_rsp_err, e[32]);
      end
    end
    if (z_rsp_valid && rsp_ready) begin
      if (qz.size() == 0) check("z_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = qz.pop_front();
        check("z_rdata", z_rsp_rdata, e[31:0]);
        check("z_err", z_rsp_err, e[32]);
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      if (a_req_ready && z_req_ready) break;
      @(posedge clk); #1;
    end
    if (k == 40) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    logic err;
    int lat_a, lat_z;
    wait_idle();
    err = exp_err(be, addr[1:0]);
    qa.push_back({err, mdl_access(0, we, addr, wdata, be, err)});
    qz.push_back({err, mdl_access(1, we, addr, wdata, be, err)});
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = ~wdata; req_addr = addr ^ 32'h4; req_be = ~be; req_we = ~we;
    lat_a = -1; lat_z = -1;
    for (int k = 0; k < 20; k++) begin
      if (lat_a < 0 && a_rsp_valid) lat_a = k;
      if (lat_z < 0 && z_rsp_valid) lat_z = k;
      if (lat_a >= 0 && lat_z >= 0) break;
      @(posedge clk); #1;
    end
    check("a_latency", lat_a, 64'd2);
    check("z_latency", lat_z, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_be = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_req_ready", a_req_ready, 64'd1);
    check("a_rst_rsp_valid", a_rsp_valid, 64'd0);
    check("a_rst_rsp_rdata", a_rsp_rdata, 64'd0);
    check("a_rst_rsp_err", a_rsp_err, 64'd0);
    check("z_rst_req_ready", z_req_ready, 64'd1);
    check("z_rst_rsp_valid", z_rsp_valid, 64'd0);
    check("z_rst_rsp_rdata", z_rsp_rdata, 64'd0);
    check("z_rst_rsp_err", z_rsp_err, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // write/read and byte merge
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
    do_req(1'b0, 32'h10, 32'h0, 4'b0000);
    do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    do_req(1'b0, 32'h10, 32'h0, 4'b0000);

    // reset during the wait states of a store
    do_req(1'b1, 32'h20, 32'h11223344, 4'b1111);
    wait_idle();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55667788; req_be = 4'b1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    void'(mdl_access(1, 1'b1, 32'h20, 32'h55667788, 4'b1111, 1'b0));
    check("a_busy_before_rst", a_req_ready, 64'd0);
    check("z_valid_before_rst", z_rsp_valid, 64'd1);
    rst = 1'b0;
    #1;
    check("a_rst_mid_valid", a_rsp_valid, 64'd0);
    check("a_rst_mid_ready", a_req_ready, 64'd1);
    check("z_rst_mid_valid", z_rsp_valid, 64'd0);
    check("z_rst_mid_ready", z_req_ready, 64'd1);
    #4;
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h20, 32'h0, 4'b0000);

    // back-pressure on a load of 0x10
    wait_idle();
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'b0000);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", a_rsp_valid, 64'd1);
      check("bp_rdata", a_rsp_rdata, 64'hDEADBEAA);
      check("bp_req_ready", a_req_ready, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_after", a_req_ready, 64'd1);
    check("bp_valid_after", a_rsp_valid, 64'd0);

    // address wrap
    do_req(1'b1, 32'h0, 32'hA5A5A5A5, 4'b1111);
    do_req(1'b0, 32'h1000, 32'h0, 4'b0000);

    // misaligned full-word store, then legal halfword store
    do_req(1'b1, 32'h22, 32'hCAFEF00D, 4'b1111);
    do_req(1'b0, 32'h20, 32'h0, 4'b0000);
    do_req(1'b1, 32'h12, 32'hBEEF0000, 4'b1100);
    do_req(1'b0, 32'h10, 32'h0, 4'b0000);

    // random traffic over a small window
    for (int i = 0; i < 8; i++) do_req(1'b1, 32'h100 + 32'(i) * 32'd4, $urandom, 4'b1111);
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 1) == 1) do_req(1'b1, a, $urandom, 4'($urandom_range(1, 15)));
      else do_req(1'b0, a, 32'h0, 4'b0000);
    end

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("a_queue_drained", qa.size(), 64'd0);
    check("z_queue_drained", qz.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
